// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Parametrised sequential ALU for the downsampling datapath.
//             Operands and opcode are captured on an accepted start. Ordinary
//             ops complete one cycle later. The optional MUL op runs a
//             shift-add loop over WIDTH cycles. Each completion raises a
//             one-cycle done pulse, with err for an illegal opcode.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     : data width of the A/B/C buses (>= 4)
//    SHW       : width of the shift-amount field taken from b_bus[SHW-1:0]
//  Ports
//    clk       in  1      : clock, all state changes on posedge
//    rst_n     in  1      : synchronous active-low reset
//    a_bus     in  WIDTH  : operand A
//    b_bus     in  WIDTH  : operand B / shift amount
//    operation in  4      : opcode
//    start     in  1      : request, accepted when busy is low
//    busy      out 1      : operation in progress
//    done      out 1      : one-cycle completion pulse
//    c_bus     out WIDTH  : result, held until the next legal completion
//    z_flag    out 1      : result is zero
//    n_flag    out 1      : result MSB
//    c_flag    out 1      : carry (ADD/INC) or borrow (SUB/DEC), else 0
//    err       out 1      : illegal opcode, pulses together with done
//  Configuration
//    ALU_SEQ_MUL_EN : when defined, opcode 1100 runs the iterative
//                     multiplier. Otherwise opcode 1100 is illegal and no
//                     multiplier logic exists.
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 24,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_bus,
    input  logic [WIDTH-1:0] b_bus,
    input  logic [3:0]       operation,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c_bus,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic             err
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_PASSA = 4'b0011;
    localparam logic [3:0] OP_PASSB = 4'b0100;
    localparam logic [3:0] OP_INC   = 4'b0101;
    localparam logic [3:0] OP_DEC   = 4'b0110;
    localparam logic [3:0] OP_SHL   = 4'b0111;
    localparam logic [3:0] OP_SHR   = 4'b1000;
    localparam logic [3:0] OP_AND   = 4'b1001;
    localparam logic [3:0] OP_OR    = 4'b1010;
    localparam logic [3:0] OP_CLR   = 4'b1011;
    localparam logic [3:0] OP_XOR   = 4'b1101;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;

`ifdef ALU_SEQ_MUL_EN
    // a_q is reused as the shifting multiplicand and b_q as the shifting
    // multiplier while in ST_MUL; acc_q holds the partial product.
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [SHW-1:0]   cnt_q;
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath from the latched operands
    // ------------------------------------------------------------------
    logic [WIDTH:0]   add_d;
    logic [WIDTH:0]   sub_d;
    logic [WIDTH:0]   inc_d;
    logic [WIDTH:0]   dec_d;
    logic [SHW-1:0]   shamt_d;
    logic             shift_oob_d;
    logic [WIDTH-1:0] res_d;
    logic             cout_d;
    logic             legal_d;

    // The extra top bit of the subtract results is the borrow (A < B).
    assign add_d   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_d   = {1'b0, a_q} - {1'b0, b_q};
    assign inc_d   = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_d   = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};
    assign shamt_d = b_q[SHW-1:0];
    // Only reachable when WIDTH is not a power of two.
    assign shift_oob_d = ({1'b0, shamt_d} >= (SHW+1)'(WIDTH));

    always_comb begin
        res_d   = '0;
        cout_d  = 1'b0;
        legal_d = 1'b1;
        case (op_q)
            OP_ADD:   begin res_d = add_d[WIDTH-1:0]; cout_d = add_d[WIDTH]; end
            OP_SUB:   begin res_d = sub_d[WIDTH-1:0]; cout_d = sub_d[WIDTH]; end
            OP_PASSA: res_d = a_q;
            OP_PASSB: res_d = b_q;
            OP_INC:   begin res_d = inc_d[WIDTH-1:0]; cout_d = inc_d[WIDTH]; end
            OP_DEC:   begin res_d = dec_d[WIDTH-1:0]; cout_d = dec_d[WIDTH]; end
            OP_SHL:   res_d = shift_oob_d ? '0 : (a_q << shamt_d);
            OP_SHR:   res_d = shift_oob_d ? '0 : (a_q >> shamt_d);
            OP_AND:   res_d = a_q & b_q;
            OP_OR:    res_d = a_q | b_q;
            OP_CLR:   res_d = '0;
            OP_XOR:   res_d = a_q ^ b_q;
            // MUL never reaches ST_EXEC when the multiplier is built in,
            // so it lands here only as an illegal opcode.
            default:  legal_d = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // One multiplier bit per cycle; the final step's sum is the product.
    assign acc_d = acc_q + (b_q[0] ? a_q : '0);
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            c_bus   <= '0;
            z_flag  <= 1'b0;
            n_flag  <= 1'b0;
            c_flag  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q  <= a_bus;
                        b_q  <= b_bus;
                        op_q <= operation;
                        busy <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                        if (operation == OP_MUL) begin
                            state_q <= ST_MUL;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_EXEC;
                        end
`else
                        state_q <= ST_EXEC;
`endif
                    end
                end

                ST_EXEC: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (legal_d) begin
                        c_bus  <= res_d;
                        z_flag <= (res_d == '0);
                        n_flag <= res_d[WIDTH-1];
                        c_flag <= cout_d;
                    end else begin
                        // Result and flags keep their previous values.
                        err <= 1'b1;
                    end
                end

`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        c_bus   <= acc_d;
                        z_flag  <= (acc_d == '0);
                        n_flag  <= acc_d[WIDTH-1];
                        c_flag  <= 1'b0;
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=24). Directed scenarios
//             plus randomized ops checked against a behavioural model.
//             Expectations follow ALU_SEQ_MUL_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 24;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] a_bus = '0;
    logic [23:0] b_bus = '0;
    logic [3:0]  operation = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [23:0] c_bus;
    logic        z_flag;
    logic        n_flag;
    logic        c_flag;
    logic        err;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .operation (operation),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .c_bus     (c_bus),
        .z_flag    (z_flag),
        .n_flag    (n_flag),
        .c_flag    (c_flag),
        .err       (err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: visible result/flags and the expected outcome
    // of the most recent op.
    logic [23:0] m_c  = '0;
    logic        m_z  = 1'b0;
    logic        m_n  = 1'b0;
    logic        m_cf = 1'b0;
    logic        m_err = 1'b0;
    int          m_lat = 1;

    // Observations from the most recent run_op.
    logic [23:0] o_c;
    logic        o_z, o_n, o_cf, o_err, o_done, o_busy_t0, o_busy_end;
    int          o_lat;

    // Behavioural model from the opcode table, using wide integer arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        longint ua, ub, r;
        int     sh;
        logic   cy, legal;
        logic [63:0] rv;
        ua = a; ub = b; r = 0; cy = 1'b0; legal = 1'b1;
        sh = int'(b[4:0]);
        case (op)
            4'h1: begin r = ua + ub; cy = (r > 64'hFFFFFF); end
            4'h2: begin r = ua - ub; cy = (ua < ub); end
            4'h3: r = ua;
            4'h4: r = ub;
            4'h5: begin r = ua + 1; cy = (r > 64'hFFFFFF); end
            4'h6: begin r = ua - 1; cy = (ua == 0); end
            4'h7: r = (sh >= WIDTH) ? 0 : (ua << sh);
            4'h8: r = (sh >= WIDTH) ? 0 : (ua >> sh);
            4'h9: r = ua & ub;
            4'hA: r = ua | ub;
            4'hB: r = 0;
            4'hC: if (MUL_EN) r = ua * ub; else legal = 1'b0;
            4'hD: r = ua ^ ub;
            default: legal = 1'b0;
        endcase
        m_err = !legal;
        m_lat = (legal && op == 4'hC) ? WIDTH : 1;
        if (legal) begin
            rv   = r;
            m_c  = rv[23:0];
            m_z  = (m_c == 24'h0);
            m_n  = m_c[23];
            m_cf = cy;
        end
    endtask

    // Drive one request, wait (bounded) for done, capture outputs, update model.
    task automatic run_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        @(negedge clk);
        operation = op; a_bus = a; b_bus = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: they must have been latched at acceptance.
        a_bus = 24'($urandom); b_bus = 24'($urandom); operation = 4'($urandom);
        o_busy_t0 = busy;
        o_lat = 0; o_done = 1'b0;
        while (o_lat < 100 && !o_done) begin
            @(posedge clk); #1;
            o_lat++;
            o_done = done;
        end
        o_c = c_bus; o_z = z_flag; o_n = n_flag; o_cf = c_flag; o_err = err;
        o_busy_end = busy;
        model_op(op, a, b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; operation = 4'h1; a_bus = 24'd5; b_bus = 24'd6;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done, err, c_bus, z_flag, n_flag, c_flag} !== 30'd0) begin
                errors++;
                $display("FAIL reset_state: busy=%b done=%b err=%b c=%h z=%b n=%b c=%b, want all 0",
                         busy, done, err, c_bus, z_flag, n_flag, c_flag);
            end
        end
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: busy=%b done=%b, want 0 0", busy, done);
        end
        m_c = '0; m_z = 1'b0; m_n = 1'b0; m_cf = 1'b0;
    endtask

    task automatic test_arith();
        run_op(4'h2, 24'd5, 24'd5);
        checks++;
        if (o_busy_t0 !== 1'b1 || o_lat !== 1 || o_busy_end !== 1'b0 || o_c !== 24'h0 ||
            o_z !== 1'b1 || o_cf !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal: busyT0=%b lat=%0d busyT1=%b c=%h z=%b cf=%b err=%b, want 1 1 0 000000 1 0 0",
                     o_busy_t0, o_lat, o_busy_end, o_c, o_z, o_cf, o_err);
        end
        run_op(4'h2, 24'd3, 24'd5);
        checks++;
        if (o_c !== 24'hFFFFFE || o_n !== 1'b1 || o_cf !== 1'b1 || o_z !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: c=%h n=%b cf=%b z=%b, want fffffe 1 1 0", o_c, o_n, o_cf, o_z);
        end
        run_op(4'h1, 24'hFFFFFF, 24'd1);
        checks++;
        if (o_c !== 24'h0 || o_z !== 1'b1 || o_cf !== 1'b1 || o_n !== 1'b0) begin
            errors++;
            $display("FAIL add_carry: c=%h z=%b cf=%b n=%b, want 000000 1 1 0", o_c, o_z, o_cf, o_n);
        end
        run_op(4'h6, 24'd0, 24'd9);
        checks++;
        if (o_c !== 24'hFFFFFF || o_cf !== 1'b1 || o_n !== 1'b1) begin
            errors++;
            $display("FAIL dec_zero: c=%h cf=%b n=%b, want ffffff 1 1", o_c, o_cf, o_n);
        end
    endtask

    task automatic test_shift();
        run_op(4'h7, 24'd1, 24'd23);
        checks++;
        if (o_c !== 24'h800000 || o_n !== 1'b1 || o_z !== 1'b0 || o_cf !== 1'b0) begin
            errors++;
            $display("FAIL shl_23: c=%h n=%b z=%b cf=%b, want 800000 1 0 0", o_c, o_n, o_z, o_cf);
        end
        run_op(4'h7, 24'd1, 24'd24);
        checks++;
        if (o_c !== 24'h0 || o_z !== 1'b1 || o_n !== 1'b0) begin
            errors++;
            $display("FAIL shl_oob: c=%h z=%b n=%b, want 000000 1 0", o_c, o_z, o_n);
        end
        run_op(4'h8, 24'h800000, 24'd4);
        checks++;
        if (o_c !== 24'h080000 || o_z !== 1'b0 || o_n !== 1'b0) begin
            errors++;
            $display("FAIL shr_4: c=%h z=%b n=%b, want 080000 0 0", o_c, o_z, o_n);
        end
    endtask

    task automatic test_mul();
        run_op(4'hC, 24'd123, 24'd456);
        checks++;
        if (MUL_EN) begin
            if (o_lat !== 24 || o_c !== 24'h00DB18 || o_err !== 1'b0 || o_cf !== 1'b0 || o_busy_end !== 1'b0) begin
                errors++;
                $display("FAIL mul: lat=%0d c=%h err=%b cf=%b busy=%b, want 24 00db18 0 0 0",
                         o_lat, o_c, o_err, o_cf, o_busy_end);
            end
        end else begin
            if (o_lat !== 1 || o_err !== 1'b1 || o_c !== 24'h080000) begin
                errors++;
                $display("FAIL mul_illegal: lat=%0d err=%b c=%h, want 1 1 080000", o_lat, o_err, o_c);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] op;
        int lat, extra;
        logic seen;
        op = MUL_EN ? 4'hC : 4'h1;
        @(negedge clk);
        operation = op; a_bus = 24'd123; b_bus = 24'd456; start = 1'b1;
        @(posedge clk); #1;
        // Keep start asserted with a different request for the whole busy time.
        operation = 4'h2; a_bus = 24'h111111; b_bus = 24'h000001;
        lat = 0; seen = 1'b0;
        while (lat < 100 && !seen) begin
            @(posedge clk); #1;
            lat++;
            seen = done;
        end
        start = 1'b0;
        model_op(op, 24'd123, 24'd456);
        checks++;
        if (lat !== m_lat || c_bus !== (MUL_EN ? 24'h00DB18 : 24'h000243)) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d c=%h, want %0d %h", lat, c_bus, m_lat,
                     MUL_EN ? 24'h00DB18 : 24'h000243);
        end
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_not_queued: extra busy/done cycles=%0d, want 0", extra);
        end
    endtask

    task automatic test_reset_midflight();
        int pulses;
        @(negedge clk);
        operation = MUL_EN ? 4'hC : 4'h1; a_bus = 24'd123; b_bus = 24'd456; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (MUL_EN ? 10 : 0) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err, c_bus, z_flag, n_flag, c_flag} !== 30'd0) begin
            errors++;
            $display("FAIL reset_midflight: busy=%b done=%b err=%b c=%h z=%b n=%b c=%b, want all 0",
                     busy, done, err, c_bus, z_flag, n_flag, c_flag);
        end
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL discard_inflight: busy/done cycles=%0d, want 0", pulses);
        end
        m_c = '0; m_z = 1'b0; m_n = 1'b0; m_cf = 1'b0;
        run_op(4'h1, 24'd2, 24'd3);
        checks++;
        if (o_lat !== 1 || o_c !== 24'd5 || o_z !== 1'b0 || o_cf !== 1'b0) begin
            errors++;
            $display("FAIL add_after_reset: lat=%0d c=%h z=%b cf=%b, want 1 000005 0 0", o_lat, o_c, o_z, o_cf);
        end
    endtask

    task automatic test_illegal();
        run_op(4'h1, 24'd3, 24'd4);
        run_op(4'h0, 24'h123456, 24'h654321);
        checks++;
        if (o_done !== 1'b1 || o_err !== 1'b1 || o_lat !== 1 || o_c !== 24'h000007 ||
            o_z !== 1'b0 || o_n !== 1'b0 || o_cf !== 1'b0) begin
            errors++;
            $display("FAIL illegal_0000: done=%b err=%b lat=%0d c=%h z=%b n=%b cf=%b, want 1 1 1 000007 0 0 0",
                     o_done, o_err, o_lat, o_c, o_z, o_n, o_cf);
        end
        run_op(4'h2, 24'd3, 24'd5);
        run_op(4'hF, 24'h000001, 24'h000001);
        checks++;
        if (o_err !== 1'b1 || o_c !== 24'hFFFFFE || o_z !== 1'b0 || o_n !== 1'b1 || o_cf !== 1'b1) begin
            errors++;
            $display("FAIL illegal_1111: err=%b c=%h z=%b n=%b cf=%b, want 1 fffffe 0 1 1",
                     o_err, o_c, o_z, o_n, o_cf);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: done=%b err=%b, want 0 0", done, err);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [23:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 24'($urandom);
            b  = (op == 4'h7 || op == 4'h8) ? 24'($urandom_range(0, 31)) : 24'($urandom);
            if (i % 7 == 0) a = 24'h000000;
            if (i % 11 == 0) a = 24'hFFFFFF;
            run_op(op, a, b);
            checks++;
            if (o_lat !== m_lat || o_err !== m_err || o_c !== m_c || o_z !== m_z ||
                o_n !== m_n || o_cf !== m_cf || o_busy_t0 !== 1'b1 || o_busy_end !== 1'b0) begin
                errors++;
                $display("FAIL random op=%h a=%h b=%h: lat=%0d err=%b c=%h z=%b n=%b cf=%b busyT0=%b busyEnd=%b, want lat=%0d err=%b c=%h z=%b n=%b cf=%b 1 0",
                         op, a, b, o_lat, o_err, o_c, o_z, o_n, o_cf, o_busy_t0, o_busy_end,
                         m_lat, m_err, m_c, m_z, m_n, m_cf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_mul();
        test_busy_ignore();
        test_reset_midflight();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
